// File: rtl/sync_fifo_param.sv
// ---------------------------------------------------------------------------
// sync_fifo_param
//   Single-clock FIFO with a registered word count, level-derived status flags,
//   and a choice of standard or first-word-fall-through read behaviour.
//   Storage is one write port plus one read port, so it maps onto a simple
//   dual-port block RAM.
//
// Optional feature macro: SYNC_FIFO_ERR_FLAG_EN
//   defined   -> sticky overflow/underflow flags, cleared only by rst_n
//   undefined -> overflow/underflow tied to 0, no error logic
//
// Parameters
//   DATA_WIDTH       word width (1..1152)
//   DEPTH_WIDTH      address width, DEPTH = 2**DEPTH_WIDTH (4..16)
//   ALMOST_FULL_NUM  almost_full when water_level >= this (1..DEPTH-1)
//   ALMOST_EMPTY_NUM almost_empty when water_level <= this (1..DEPTH-1)
//   FWFT             0 = standard read (1-cycle latency), 1 = fall-through
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   wr_en, wr_data      write request and data
//   wr_full             FIFO holds DEPTH words
//   almost_full         level at or above ALMOST_FULL_NUM
//   rd_en, rd_data      read request and data
//   rd_empty            FIFO holds 0 words
//   almost_empty        level at or below ALMOST_EMPTY_NUM
//   water_level         stored word count (DEPTH_WIDTH+1 bits)
//   overflow/underflow  sticky error flags
// ---------------------------------------------------------------------------
module sync_fifo_param #(
  parameter int DATA_WIDTH       = 32,
  parameter int DEPTH_WIDTH      = 11,
  parameter int ALMOST_FULL_NUM  = 1020,
  parameter int ALMOST_EMPTY_NUM = 4,
  parameter int FWFT             = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   wr_full,
  output logic                   almost_full,
  input  logic                   rd_en,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   rd_empty,
  output logic                   almost_empty,
  output logic [DEPTH_WIDTH:0]   water_level,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int DEPTH = 1 << DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0]   LVL_ZERO = (DEPTH_WIDTH+1)'(0);
  localparam logic [DEPTH_WIDTH:0]   LVL_ONE  = (DEPTH_WIDTH+1)'(1);
  localparam logic [DEPTH_WIDTH:0]   LVL_FULL = (DEPTH_WIDTH+1)'(DEPTH);
  localparam logic [DEPTH_WIDTH:0]   LVL_AF   = (DEPTH_WIDTH+1)'(ALMOST_FULL_NUM);
  localparam logic [DEPTH_WIDTH:0]   LVL_AE   = (DEPTH_WIDTH+1)'(ALMOST_EMPTY_NUM);
  localparam logic [DEPTH_WIDTH-1:0] PTR_ZERO = DEPTH_WIDTH'(0);
  localparam logic [DEPTH_WIDTH-1:0] PTR_ONE  = DEPTH_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0]  DATA_ZERO = DATA_WIDTH'(0);

  logic [DATA_WIDTH-1:0]  mem_r [DEPTH];
  logic [DEPTH_WIDTH-1:0] wr_ptr_r, rd_ptr_r;
  logic [DEPTH_WIDTH-1:0] wr_ptr_next_s, rd_ptr_next_s;
  logic [DEPTH_WIDTH:0]   level_r, level_next_s;
  logic                   full_r, empty_r, af_r, ae_r;
  logic                   wr_accept_s, rd_accept_s;
  logic [DATA_WIDTH-1:0]  rd_data_r;

  // Request acceptance, next pointers and next level. Gating on the
  // registered full/empty flags gives read priority when full and write
  // priority when empty without any extra arbitration.
  always_comb begin
    wr_accept_s   = wr_en & ~full_r;
    rd_accept_s   = rd_en & ~empty_r;
    wr_ptr_next_s = wr_ptr_r;
    rd_ptr_next_s = rd_ptr_r;
    level_next_s  = level_r;
    if (wr_accept_s) begin
      wr_ptr_next_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_next_s = wr_ptr_r;
    end
    if (rd_accept_s) begin
      rd_ptr_next_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_next_s = rd_ptr_r;
    end
    case ({wr_accept_s, rd_accept_s})
      2'b10:   level_next_s = level_r + LVL_ONE;
      2'b01:   level_next_s = level_r - LVL_ONE;
      default: level_next_s = level_r;
    endcase
  end

  // Pointers, level, and flags. Flags are registered from the next level so
  // they always equal a decode of the registered water_level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      level_r  <= LVL_ZERO;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      af_r     <= 1'b0;
      ae_r     <= 1'b1;
    end else begin
      wr_ptr_r <= wr_ptr_next_s;
      rd_ptr_r <= rd_ptr_next_s;
      level_r  <= level_next_s;
      full_r   <= (level_next_s == LVL_FULL);
      empty_r  <= (level_next_s == LVL_ZERO);
      af_r     <= (level_next_s >= LVL_AF);
      ae_r     <= (level_next_s <= LVL_AE);
    end
  end

  // Storage write port; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_accept_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      logic bypass_s;

      // The word that will sit at the head after this edge is being written
      // right now when the write slot equals the next read slot; forward it.
      always_comb begin
        bypass_s = wr_accept_s & (wr_ptr_r == rd_ptr_next_s);
      end

      // Head-of-queue register: prefetches the word at the next read pointer
      // every cycle so the head is visible with zero read latency.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_data_r <= DATA_ZERO;
        end else if (bypass_s) begin
          rd_data_r <= wr_data;
        end else begin
          rd_data_r <= mem_r[rd_ptr_next_s];
        end
      end
    end else begin : g_std
      // Standard read port: loads the word on an accepted read, else holds.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_data_r <= DATA_ZERO;
        end else if (rd_accept_s) begin
          rd_data_r <= mem_r[rd_ptr_r];
        end
      end
    end
  endgenerate

`ifdef SYNC_FIFO_ERR_FLAG_EN
  logic overflow_r, underflow_r;

  // Sticky error flags: any request made against a full/empty FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wr_en && full_r) begin
        overflow_r <= 1'b1;
      end
      if (rd_en && empty_r) begin
        underflow_r <= 1'b1;
      end
    end
  end

  assign overflow  = overflow_r;
  assign underflow = underflow_r;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign wr_full      = full_r;
  assign rd_empty     = empty_r;
  assign almost_full  = af_r;
  assign almost_empty = ae_r;
  assign water_level  = level_r;
  assign rd_data      = rd_data_r;

endmodule

// File: tb/tb_sync_fifo_param.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_param
//   Directed, self-checking bench. u_std is a standard-read FIFO driven by a
//   vector table and hand-written sequences; u_fwft is a fall-through FIFO
//   used for the zero-latency read sequence. Both share clk and rst_n.
//   DEPTH = 16, almost_full at >= 14, almost_empty at <= 2.
// ---------------------------------------------------------------------------
module tb_sync_fifo_param;

  logic        clk;
  logic        rst_n;

  logic        wr_en, rd_en;
  logic [31:0] wr_data;
  logic        wr_full, almost_full, rd_empty, almost_empty, overflow, underflow;
  logic [31:0] rd_data;
  logic [4:0]  water_level;

  logic        f_wr_en, f_rd_en;
  logic [31:0] f_wr_data;
  logic        f_wr_full, f_almost_full, f_rd_empty, f_almost_empty, f_overflow, f_underflow;
  logic [31:0] f_rd_data;
  logic [4:0]  f_water_level;

  int checks;
  int errors;

  sync_fifo_param #(.DATA_WIDTH(32), .DEPTH_WIDTH(4), .ALMOST_FULL_NUM(14),
                    .ALMOST_EMPTY_NUM(2), .FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full), .almost_full(almost_full),
    .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty), .almost_empty(almost_empty),
    .water_level(water_level), .overflow(overflow), .underflow(underflow)
  );

  sync_fifo_param #(.DATA_WIDTH(32), .DEPTH_WIDTH(4), .ALMOST_FULL_NUM(14),
                    .ALMOST_EMPTY_NUM(2), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n),
    .wr_en(f_wr_en), .wr_data(f_wr_data), .wr_full(f_wr_full), .almost_full(f_almost_full),
    .rd_en(f_rd_en), .rd_data(f_rd_data), .rd_empty(f_rd_empty), .almost_empty(f_almost_empty),
    .water_level(f_water_level), .overflow(f_overflow), .underflow(f_underflow)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] din;
    logic [4:0]  lvl;
    logic        full;
    logic        empty;
    logic        af;
    logic        ae;
    logic        chk_d;
    logic [31:0] dout;
  } vec_t;

  vec_t vt[64];
  int   nv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic wr, input logic rd, input logic [31:0] din,
                     input int lvl, input logic full, input logic empty,
                     input logic af, input logic ae, input logic chk_d,
                     input logic [31:0] dout);
    vt[nv].wr = wr;  vt[nv].rd = rd;  vt[nv].din = din;
    vt[nv].lvl = 5'(lvl); vt[nv].full = full; vt[nv].empty = empty;
    vt[nv].af = af;  vt[nv].ae = ae;  vt[nv].chk_d = chk_d; vt[nv].dout = dout;
    nv++;
  endtask

  // One cycle on u_std: drive on the falling edge, sample 1 after the rise.
  task automatic step(input logic wr, input logic rd, input logic [31:0] din);
    @(negedge clk);
    wr_en = wr; rd_en = rd; wr_data = din;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input string tag, input int lvl, input logic full,
                           input logic empty, input logic af, input logic ae);
    chk({tag, ".level"}, {27'd0, water_level}, 32'(lvl));
    chk({tag, ".full"},  {31'd0, wr_full},      {31'd0, full});
    chk({tag, ".empty"}, {31'd0, rd_empty},     {31'd0, empty});
    chk({tag, ".af"},    {31'd0, almost_full},  {31'd0, af});
    chk({tag, ".ae"},    {31'd0, almost_empty}, {31'd0, ae});
  endtask

  logic [31:0] sb[$];
  logic [31:0] exp_d;
  logic        exp_err;

  initial begin
    checks = 0; errors = 0; nv = 0;
`ifdef SYNC_FIFO_ERR_FLAG_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    rst_n = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0; wr_data = 32'd0;
    f_wr_en = 1'b0; f_rd_en = 1'b0; f_wr_data = 32'd0;

    // ---- reset state ----
    #12;
    chk_flags("reset", 0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("reset.rd_data", rd_data, 32'd0);
    chk("reset.ovf", {31'd0, overflow},  32'd0);
    chk("reset.udf", {31'd0, underflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- vector table: fill, full boundary, drain, empty boundary ----
    for (int k = 0; k < 16; k++)
      add(1'b1, 1'b0, 32'(k), k + 1, (k + 1) == 16, 1'b0, (k + 1) >= 14, (k + 1) <= 2,
          1'b0, 32'd0);
    // full + wr + rd: only the read happens, 0xDEADBEEF is dropped
    add(1'b1, 1'b1, 32'hDEAD_BEEF, 15, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
    for (int k = 1; k < 16; k++)
      add(1'b0, 1'b1, 32'd0, 15 - k, 1'b0, (15 - k) == 0, (15 - k) >= 14, (15 - k) <= 2,
          1'b1, 32'(k));
    // empty + wr + rd: only the write happens, rd_data holds 0x0F
    add(1'b1, 1'b1, 32'h77, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0F);
    add(1'b0, 1'b1, 32'd0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h77);
    // read while empty: rejected, nothing changes
    add(1'b0, 1'b1, 32'd0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h77);

    for (int i = 0; i < nv; i++) begin
      step(vt[i].wr, vt[i].rd, vt[i].din);
      chk_flags($sformatf("vec%0d", i), int'(vt[i].lvl), vt[i].full, vt[i].empty,
                vt[i].af, vt[i].ae);
      if (vt[i].chk_d)
        chk($sformatf("vec%0d.rd_data", i), rd_data, vt[i].dout);
    end

    // ---- sticky error flags ----
    step(1'b0, 1'b0, 32'd0);
    chk("err.ovf", {31'd0, overflow},  {31'd0, exp_err});
    chk("err.udf", {31'd0, underflow}, {31'd0, exp_err});
    step(1'b0, 1'b0, 32'd0);
    chk("err.udf_hold", {31'd0, underflow}, {31'd0, exp_err});

    // ---- wrap-around stream at level 5 ----
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, 32'(100 + k));
      sb.push_back(32'(100 + k));
    end
    chk("wrap.prefill", {27'd0, water_level}, 32'd5);
    for (int j = 0; j < 40; j++) begin
      step(1'b1, 1'b1, 32'(105 + j));
      sb.push_back(32'(105 + j));
      exp_d = sb.pop_front();
      chk($sformatf("wrap%0d.rd_data", j), rd_data, exp_d);
      chk($sformatf("wrap%0d.level", j), {27'd0, water_level}, 32'd5);
    end
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 32'(200 + k));
    chk("pre_rst.level", {27'd0, water_level}, 32'd9);

    // ---- asynchronous reset at level 9, no clock edge ----
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    rst_n = 1'b0;
    #2;
    chk_flags("async_rst", 0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("async_rst.rd_data", rd_data, 32'd0);
    chk("async_rst.ovf", {31'd0, overflow},  32'd0);
    chk("async_rst.udf", {31'd0, underflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- standard-read latency; also proves the old words were discarded ----
    step(1'b1, 1'b0, 32'hA5A5_A5A5);
    chk_flags("std_lat.wr", 1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("std_lat.hold", rd_data, 32'd0);
    step(1'b0, 1'b1, 32'd0);
    chk("std_lat.rd_data", rd_data, 32'hA5A5_A5A5);
    chk("std_lat.empty", {31'd0, rd_empty}, 32'd1);
    step(1'b0, 1'b0, 32'd0);

    // ---- fall-through latency on u_fwft ----
    @(negedge clk);
    f_wr_en = 1'b1; f_wr_data = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    chk("fwft.empty_fall", {31'd0, f_rd_empty}, 32'd0);
    chk("fwft.rd_data0", f_rd_data, 32'hA5A5_A5A5);
    @(negedge clk);
    f_wr_data = 32'h5A5A_5A5A;
    @(posedge clk); #1;
    chk("fwft.head_hold", f_rd_data, 32'hA5A5_A5A5);
    chk("fwft.level2", {27'd0, f_water_level}, 32'd2);
    @(negedge clk);
    f_wr_en = 1'b0; f_rd_en = 1'b1;
    @(posedge clk); #1;
    chk("fwft.rd_data1", f_rd_data, 32'h5A5A_5A5A);
    @(posedge clk); #1;
    chk("fwft.empty", {31'd0, f_rd_empty}, 32'd1);
    @(negedge clk);
    f_rd_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
